channel_sequencer: RTL and testbench

//   Parametrised successor to the DIP-switch channel selector. Picks the ADC channel for the SPI

---
 rtl/chseq_pkg.sv | 40 ++++
 rtl/channel_sequencer_sw_debounce.sv | 58 +++++
 rtl/channel_sequencer.sv | 128 ++++++++++++
 tb/tb_channel_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chseq_pkg.sv
// Shared types and helpers for the channel sequencer: FSM states, address-width
// derivation and the scan-order search over the channel enable mask.
package chseq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SELECT    = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam int unsigned MAX_CH = 16;

    function automatic int unsigned addr_width(input int unsigned num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Lowest set bit strictly above cur, otherwise the lowest set bit overall.
    function automatic logic [3:0] next_set_bit(input logic [MAX_CH-1:0] mask,
                                                input logic [3:0]        cur);
        logic [3:0] nxt;
        logic       found;
        nxt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (!found && mask[i] && (i > 32'(cur))) begin
                nxt   = 4'(i);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (!found && mask[i]) begin
                nxt   = 4'(i);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/channel_sequencer_sw_debounce.sv
// Two-flop synchroniser for the switch bus, followed by an optional stability
// filter enabled by CHSEQ_DEBOUNCE_EN.
module sw_debounce #(
    parameter int unsigned W            = 9,
    parameter int unsigned DEBOUNCE_CYC = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sw_i,
    output logic [W-1:0] sw_o
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef CHSEQ_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [W-1:0]     cand_q;
    logic [W-1:0]     sw_q;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q is the number of consecutive cycles sync2_q has held cand_q's value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= '0;
            sw_q   <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= sync2_q;
            if (sync2_q != cand_q) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                sw_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign sw_o = sw_q;
`else
    logic [31:0] unused_debounce_cyc;
    assign unused_debounce_cyc = DEBOUNCE_CYC;
    assign sw_o                = sync2_q;
`endif

endmodule

// File: rtl/channel_sequencer.sv
// ADC channel sequencer: manual or auto-scan channel choice, valid/ready hand-off
// to the SPI master, conversion-done wait with timeout. Optional CHSEQ_DEBOUNCE_EN.
module channel_sequencer
    import chseq_pkg::*;
#(
    parameter int unsigned NUM_CH       = 8,
    parameter int unsigned ADDR_W       = addr_width(NUM_CH),
    parameter int unsigned SW_W         = 8,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned TIMEOUT_CYC  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw_chan,
    input  logic              sw_mode,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              ch_valid,
    output logic [ADDR_W-1:0] ch_addr,
    input  logic              ch_ready,
    input  logic              conv_done,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [SW_W:0]       sw_s;
    logic [ADDR_W-1:0]   chan_s;
    logic                mode_s;
    logic                unused_sw_hi;
    logic [MAX_CH-1:0]   mask_ext;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;

    sw_debounce #(
        .W            (SW_W + 1),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sw_debounce (
        .clk   (clk),
        .reset (reset),
        .sw_i  ({sw_mode, sw_chan}),
        .sw_o  (sw_s)
    );

    assign mode_s       = sw_s[SW_W];
    assign chan_s       = sw_s[ADDR_W-1:0];
    assign unused_sw_hi = ^sw_s[SW_W-1:ADDR_W];

    always_comb begin
        mask_ext             = '0;
        mask_ext[NUM_CH-1:0] = ch_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            led_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            led_q   <= led_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        led_d   = led_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: state_d = SELECT;
            SELECT: begin
                if (mode_s) begin
                    if (ch_mask == '0) begin
                        led_d = '0;
                    end else begin
                        addr_d  = ADDR_W'(next_set_bit(mask_ext, 4'(addr_q)));
                        led_d   = LED_W'(1) << addr_d;
                        state_d = ISSUE;
                    end
                end else begin
                    // Out-of-range manual values re-issue the previous channel.
                    if (32'(chan_s) < NUM_CH) begin
                        addr_d = chan_s;
                    end
                    led_d   = LED_W'(1) << addr_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ch_ready) begin
                    tmo_d   = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (conv_done) begin
                    state_d = SELECT;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = SELECT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ch_valid    = (state_q == ISSUE);
    assign busy        = (state_q == ISSUE) || (state_q == WAIT_DONE);
    assign ch_addr     = addr_q;
    assign led         = led_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed self-checking bench for channel_sequencer (NUM_CH=8, TIMEOUT_CYC=16,
// DEBOUNCE_CYC=8); the debounce scenario is included when CHSEQ_DEBOUNCE_EN is defined.
module tb_channel_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw_chan = '0;
    logic       sw_mode = 1'b0;
    logic [7:0] ch_mask = '0;
    logic       ch_valid;
    logic [2:0] ch_addr;
    logic       ch_ready = 1'b0;
    logic       conv_done = 1'b0;
    logic [7:0] led;
    logic       busy;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_sequencer #(
        .NUM_CH       (8),
        .SW_W         (8),
        .LED_W        (8),
        .DEBOUNCE_CYC (8),
        .TIMEOUT_CYC  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_chan     (sw_chan),
        .sw_mode     (sw_mode),
        .ch_mask     (ch_mask),
        .ch_valid    (ch_valid),
        .ch_addr     (ch_addr),
        .ch_ready    (ch_ready),
        .conv_done   (conv_done),
        .led         (led),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (ch_valid === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    // Waits for an offer, holds ready low for 'hold' cycles, then handshakes (and completes).
    task automatic transact(input int hold, input bit send_done, output bit ok,
                            output logic [2:0] addr, output logic [7:0] l);
        addr = '0;
        l    = '0;
        wait_valid(ok);
        if (ok) begin
            addr = ch_addr;
            l    = led;
            repeat (hold) tick();
            ch_ready = 1'b1;
            tick();
            ch_ready = 1'b0;
            if (send_done) begin
                conv_done = 1'b1;
                tick();
                conv_done = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({ch_valid, ch_addr, led, busy, err_timeout} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b addr=%0d led=%h busy=%b err=%b required all zero",
                     ch_valid, ch_addr, led, busy, err_timeout);
        end
    endtask

    task automatic test_manual();
        bit ok;
        logic [2:0] a;
        logic [7:0] l;
        sw_chan = 8'd5; sw_mode = 1'b0; ch_mask = 8'hFF;
        do_reset();
        transact(16, 1'b1, ok, a, l);
        for (int t = 0; t < 4; t++) begin
            transact(0, 1'b1, ok, a, l);
            checks++;
            if (ok !== 1'b1 || a !== 3'd5 || l !== 8'b0010_0000) begin
                errors++;
                $display("FAIL manual_%0d: got ok=%b addr=%0d led=%h required ok=1 addr=5 led=20", t, ok, a, l);
            end
        end
    endtask

    task automatic test_scan();
        bit ok;
        logic [2:0] a;
        logic [7:0] l;
        logic [2:0] exp_a [6] = '{3'd1, 3'd2, 3'd5, 3'd7, 3'd1, 3'd2};
        logic [7:0] exp_l [6] = '{8'h02, 8'h04, 8'h20, 8'h80, 8'h02, 8'h04};
        sw_chan = 8'd0; sw_mode = 1'b1; ch_mask = 8'b1010_0110;
        do_reset();
        // First selection still sees the cleared synchroniser: manual mode, channel 0.
        transact(16, 1'b1, ok, a, l);
        checks++;
        if (ok !== 1'b1 || a !== 3'd0) begin
            errors++;
            $display("FAIL scan_first: got ok=%b addr=%0d required ok=1 addr=0", ok, a);
        end
        for (int t = 0; t < 6; t++) begin
            transact(0, 1'b1, ok, a, l);
            checks++;
            if (ok !== 1'b1 || a !== exp_a[t] || l !== exp_l[t]) begin
                errors++;
                $display("FAIL scan_%0d: got ok=%b addr=%0d led=%h required addr=%0d led=%h",
                         t, ok, a, l, exp_a[t], exp_l[t]);
            end
        end
    endtask

    task automatic test_hold_ready();
        bit ok;
        logic [2:0] a;
        logic [7:0] l;
        sw_chan = 8'd3; sw_mode = 1'b0; ch_mask = 8'hFF;
        do_reset();
        transact(16, 1'b1, ok, a, l);
        wait_valid(ok);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) sw_chan = 8'd6;
            checks++;
            if (ch_valid !== 1'b1 || ch_addr !== 3'd3 || led !== 8'h08) begin
                errors++;
                $display("FAIL hold_ready_c%0d: got valid=%b addr=%0d led=%h required valid=1 addr=3 led=08",
                         c, ch_valid, ch_addr, led);
            end
            tick();
        end
        ch_ready = 1'b1;
        tick();
        ch_ready = 1'b0;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        transact(0, 1'b1, ok, a, l);
        checks++;
        if (ok !== 1'b1 || a !== 3'd6 || l !== 8'h40) begin
            errors++;
            $display("FAIL hold_ready_next: got ok=%b addr=%0d led=%h required addr=6 led=40", ok, a, l);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        int n;
        logic [2:0] a;
        logic [7:0] l;
        sw_chan = 8'd2; sw_mode = 1'b0; ch_mask = 8'hFF;
        do_reset();
        transact(16, 1'b1, ok, a, l);
        wait_valid(ok);
        // conv_done coincident with the handshake must not end the wait.
        ch_ready = 1'b1;
        conv_done = 1'b1;
        tick();
        ch_ready = 1'b0;
        conv_done = 1'b0;
        checks++;
        if (ch_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: got valid=%b busy=%b required valid=0 busy=1", ch_valid, busy);
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (err_timeout === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 16) begin
            errors++;
            $display("FAIL timeout_delay: got seen=%b cycles=%0d required seen=1 cycles=16", seen, n);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: got err=%b required 0", err_timeout);
        end
        transact(0, 1'b1, ok, a, l);
        checks++;
        if (ok !== 1'b1 || a !== 3'd2) begin
            errors++;
            $display("FAIL timeout_next: got ok=%b addr=%0d required ok=1 addr=2", ok, a);
        end
    endtask

    task automatic test_mask_zero();
        bit ok;
        logic [2:0] a;
        logic [7:0] l;
        sw_chan = 8'd0; sw_mode = 1'b1; ch_mask = 8'h00;
        do_reset();
        transact(16, 1'b1, ok, a, l);
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (ch_valid !== 1'b0 || led !== 8'h00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mask_zero_c%0d: got valid=%b led=%h busy=%b required 0/00/0", c, ch_valid, led, busy);
            end
            tick();
        end
        ch_mask = 8'h08;
        for (int t = 0; t < 3; t++) begin
            transact(0, 1'b1, ok, a, l);
            checks++;
            if (ok !== 1'b1 || a !== 3'd3 || l !== 8'h08) begin
                errors++;
                $display("FAIL single_mask_%0d: got ok=%b addr=%0d led=%h required addr=3 led=08", t, ok, a, l);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        logic [2:0] a;
        logic [7:0] l;
        sw_chan = 8'd4; sw_mode = 1'b0; ch_mask = 8'hFF;
        do_reset();
        transact(16, 1'b1, ok, a, l);
        transact(0, 1'b0, ok, a, l);
        checks++;
        if (ok !== 1'b1 || busy !== 1'b1 || led !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset_wait: got ok=%b busy=%b led=%h required 1/1/10", ok, busy, led);
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (ch_valid !== 1'b0 || led !== 8'h00 || busy !== 1'b0 || err_timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_wait_c%0d: got valid=%b led=%h busy=%b err=%b required all zero",
                         c, ch_valid, led, busy, err_timeout);
            end
        end
        reset = 1'b0;
    endtask

`ifdef CHSEQ_DEBOUNCE_EN
    task automatic test_debounce();
        bit ok;
        logic [2:0] a;
        logic [7:0] l;
        sw_chan = 8'd1; sw_mode = 1'b0; ch_mask = 8'hFF;
        do_reset();
        transact(20, 1'b1, ok, a, l);
        wait_valid(ok);
        sw_chan = 8'd4;
        repeat (5) tick();
        sw_chan = 8'd1;
        repeat (20) tick();
        ch_ready = 1'b1; tick(); ch_ready = 1'b0;
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        transact(0, 1'b0, ok, a, l);
        checks++;
        if (ok !== 1'b1 || a !== 3'd1) begin
            errors++;
            $display("FAIL debounce_glitch: got ok=%b addr=%0d required ok=1 addr=1", ok, a);
        end
        sw_chan = 8'd4;
        repeat (20) tick();
        conv_done = 1'b1; tick(); conv_done = 1'b0;
        transact(0, 1'b1, ok, a, l);
        checks++;
        if (ok !== 1'b1 || a !== 3'd4) begin
            errors++;
            $display("FAIL debounce_accept: got ok=%b addr=%0d required ok=1 addr=4", ok, a);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_hold_ready();
        test_timeout();
        test_mask_zero();
        test_reset_in_wait();
`ifdef CHSEQ_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
